// File: rtl/seg_decoder.sv
// Segmentation back-end: 4-class argmax over signed fixed-point scores plus uint confidence, 3-cycle latency.
// Define SEG_HIST_EN to compile in the per-frame class histogram (hist_out / hist_valid).
module seg_decoder #(
    parameter int W_HEIGHT  = 480,
    parameter int W_WIDTH   = 640,
    parameter int UINT_BITW = 8,
    parameter int INT_BITW  = 5,
    parameter int FRAC_BITW = 8,
    localparam int FIXED_BITW = INT_BITW + FRAC_BITW,
    localparam int V_BITW     = $clog2(W_HEIGHT),
    localparam int H_BITW     = $clog2(W_WIDTH),
    localparam int CNT_BITW   = V_BITW + H_BITW + 1
) (
    input  logic                      clock,
    input  logic                      n_rst,
    input  logic [0:FIXED_BITW*4-1]   in_y,
    input  logic [V_BITW-1:0]         in_vcnt,
    input  logic [H_BITW-1:0]         in_hcnt,
    output logic [1:0]                out_label,
    output logic [UINT_BITW-1:0]      out_conf,
    output logic [V_BITW-1:0]         out_vcnt,
    output logic [H_BITW-1:0]         out_hcnt,
    output logic                      out_valid
`ifdef SEG_HIST_EN
    ,
    output logic [0:CNT_BITW*4-1]     hist_out,
    output logic                      hist_valid
`endif
);

    localparam int RND_SHIFT = (FRAC_BITW > UINT_BITW) ? (FRAC_BITW - UINT_BITW - 1) : 0;
    localparam logic [FIXED_BITW-1:0] UMAX = FIXED_BITW'((2 ** UINT_BITW) - 1);

    logic signed [FIXED_BITW-1:0] ch [4];

    logic signed [FIXED_BITW-1:0] s1_a_val_q, s1_a_val_d, s1_b_val_q, s1_b_val_d;
    logic                         s1_a_idx_q, s1_a_idx_d, s1_b_idx_q, s1_b_idx_d;
    logic [V_BITW-1:0]            s1_v_q, s1_v_d, s2_v_q, s2_v_d, s3_v_q, s3_v_d;
    logic [H_BITW-1:0]            s1_h_q, s1_h_d, s2_h_q, s2_h_d, s3_h_q, s3_h_d;
    logic signed [FIXED_BITW-1:0] s2_val_q, s2_val_d;
    logic [1:0]                   s2_label_q, s2_label_d, s3_label_q, s3_label_d;
    logic [UINT_BITW-1:0]         s3_conf_q, s3_conf_d;
    logic [2:0]                   vld_q, vld_d;

    logic [FIXED_BITW-2:0]        mag;
    logic [FIXED_BITW-1:0]        rnd_sum, conv;
    logic                         b_wins;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            ch[k] = in_y[k*FIXED_BITW +: FIXED_BITW];
        end

        // Strict greater-than keeps ties on the lower index in both stages.
        s1_a_idx_d = (ch[1] > ch[0]);
        s1_a_val_d = s1_a_idx_d ? ch[1] : ch[0];
        s1_b_idx_d = (ch[3] > ch[2]);
        s1_b_val_d = s1_b_idx_d ? ch[3] : ch[2];
        s1_v_d     = in_vcnt;
        s1_h_d     = in_hcnt;

        b_wins     = (s1_b_val_q > s1_a_val_q);
        s2_val_d   = b_wins ? s1_b_val_q : s1_a_val_q;
        s2_label_d = b_wins ? {1'b1, s1_b_idx_q} : {1'b0, s1_a_idx_q};
        s2_v_d     = s1_v_q;
        s2_h_d     = s1_h_q;

        mag     = s2_val_q[FIXED_BITW-2:0];
        rnd_sum = ({1'b0, mag} >> RND_SHIFT) + FIXED_BITW'(1);
        if (s2_val_q[FIXED_BITW-1]) begin
            conv = '0;
        end else if (FRAC_BITW == UINT_BITW) begin
            conv = {1'b0, mag};
        end else begin
            conv = rnd_sum >> 1;
        end
        s3_conf_d  = (conv > UMAX) ? '1 : conv[UINT_BITW-1:0];
        s3_label_d = s2_label_q;
        s3_v_d     = s2_v_q;
        s3_h_d     = s2_h_q;

        vld_d = {vld_q[1:0], 1'b1};
    end

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            s1_a_val_q <= '0;
            s1_a_idx_q <= 1'b0;
            s1_b_val_q <= '0;
            s1_b_idx_q <= 1'b0;
            s1_v_q     <= '0;
            s1_h_q     <= '0;
            s2_val_q   <= '0;
            s2_label_q <= '0;
            s2_v_q     <= '0;
            s2_h_q     <= '0;
            s3_conf_q  <= '0;
            s3_label_q <= '0;
            s3_v_q     <= '0;
            s3_h_q     <= '0;
            vld_q      <= '0;
        end else begin
            s1_a_val_q <= s1_a_val_d;
            s1_a_idx_q <= s1_a_idx_d;
            s1_b_val_q <= s1_b_val_d;
            s1_b_idx_q <= s1_b_idx_d;
            s1_v_q     <= s1_v_d;
            s1_h_q     <= s1_h_d;
            s2_val_q   <= s2_val_d;
            s2_label_q <= s2_label_d;
            s2_v_q     <= s2_v_d;
            s2_h_q     <= s2_h_d;
            s3_conf_q  <= s3_conf_d;
            s3_label_q <= s3_label_d;
            s3_v_q     <= s3_v_d;
            s3_h_q     <= s3_h_d;
            vld_q      <= vld_d;
        end
    end

    assign out_label = s3_label_q;
    assign out_conf  = s3_conf_q;
    assign out_vcnt  = s3_v_q;
    assign out_hcnt  = s3_h_q;
    assign out_valid = vld_q[2];

`ifdef SEG_HIST_EN
    typedef enum logic {H_IDLE, H_COUNT} hist_state_e;

    localparam logic [V_BITW-1:0] LAST_V = V_BITW'(W_HEIGHT - 1);
    localparam logic [H_BITW-1:0] LAST_H = H_BITW'(W_WIDTH - 1);

    hist_state_e                  state_q, state_d;
    logic [3:0][CNT_BITW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [0:CNT_BITW*4-1]        hist_q, hist_d;
    logic                         hist_vld_q, hist_vld_d;
    logic                         is_first, is_last, take;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hist_d     = hist_q;
        hist_vld_d = 1'b0;

        is_first = vld_q[2] && (s3_v_q == '0) && (s3_h_q == '0);
        is_last  = vld_q[2] && (s3_v_q == LAST_V) && (s3_h_q == LAST_H);
        take     = is_first || ((state_q == H_COUNT) && vld_q[2]);

        // A (0,0) pixel always restarts the counts, even mid-frame.
        cnt_inc             = is_first ? '0 : cnt_q;
        cnt_inc[s3_label_q] = cnt_inc[s3_label_q] + 1'b1;

        if (take) begin
            state_d = H_COUNT;
            cnt_d   = cnt_inc;
            if (is_last) begin
                for (int k = 0; k < 4; k++) begin
                    hist_d[k*CNT_BITW +: CNT_BITW] = cnt_inc[k];
                end
                hist_vld_d = 1'b1;
                cnt_d      = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= H_IDLE;
            cnt_q      <= '0;
            hist_q     <= '0;
            hist_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hist_q     <= hist_d;
            hist_vld_q <= hist_vld_d;
        end
    end

    assign hist_out   = hist_q;
    assign hist_valid = hist_vld_q;
`endif

endmodule

// File: tb/tb_seg_decoder.sv
// Directed bench for seg_decoder on a 4x4 window: an 8-bit and a 6-bit confidence instance share one stream.
module tb_seg_decoder;
  localparam int F  = 13;
  localparam int CB = 5;

  logic              clk;
  logic              rst_n;
  logic [0:F*4-1]    in_y;
  logic [1:0]        in_vcnt;
  logic [1:0]        in_hcnt;
  logic [1:0]        out_label, out_label6;
  logic [7:0]        out_conf;
  logic [5:0]        out_conf6;
  logic [1:0]        out_vcnt, out_vcnt6;
  logic [1:0]        out_hcnt, out_hcnt6;
  logic              out_valid, out_valid6;
`ifdef SEG_HIST_EN
  logic [0:CB*4-1]   hist_out, hist_out6;
  logic              hist_valid, hist_valid6;
`endif

  int total  = 0;
  int passed = 0;
  int failed = 0;

  seg_decoder #(.W_HEIGHT(4), .W_WIDTH(4), .UINT_BITW(8), .INT_BITW(5), .FRAC_BITW(8)) u_dut (
    .clock(clk), .n_rst(rst_n), .in_y(in_y), .in_vcnt(in_vcnt), .in_hcnt(in_hcnt),
    .out_label(out_label), .out_conf(out_conf), .out_vcnt(out_vcnt), .out_hcnt(out_hcnt),
    .out_valid(out_valid)
`ifdef SEG_HIST_EN
    , .hist_out(hist_out), .hist_valid(hist_valid)
`endif
  );

  seg_decoder #(.W_HEIGHT(4), .W_WIDTH(4), .UINT_BITW(6), .INT_BITW(5), .FRAC_BITW(8)) u_dut6 (
    .clock(clk), .n_rst(rst_n), .in_y(in_y), .in_vcnt(in_vcnt), .in_hcnt(in_hcnt),
    .out_label(out_label6), .out_conf(out_conf6), .out_vcnt(out_vcnt6), .out_hcnt(out_hcnt6),
    .out_valid(out_valid6)
`ifdef SEG_HIST_EN
    , .hist_out(hist_out6), .hist_valid(hist_valid6)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SEG_HIST_EN
  int pulse_cnt = 0;
  int run_len   = 0;
  int max_run   = 0;
  always @(negedge clk) begin
    if (hist_valid) begin
      run_len = run_len + 1;
      if (run_len == 1) pulse_cnt = pulse_cnt + 1;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  end

  function automatic logic [0:CB*4-1] mk_hist(input int c0, input int c1, input int c2, input int c3);
    logic [0:CB*4-1] h;
    h[0*CB +: CB] = CB'(c0);
    h[1*CB +: CB] = CB'(c1);
    h[2*CB +: CB] = CB'(c2);
    h[3*CB +: CB] = CB'(c3);
    return h;
  endfunction
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_px(input int v, input int h,
                        input logic [F-1:0] c0, input logic [F-1:0] c1,
                        input logic [F-1:0] c2, input logic [F-1:0] c3);
    in_vcnt = 2'(v);
    in_hcnt = 2'(h);
    in_y[0*F +: F] = c0;
    in_y[1*F +: F] = c1;
    in_y[2*F +: F] = c2;
    in_y[3*F +: F] = c3;
  endtask

  task automatic apply(input string tag, input int v, input int h,
                       input logic [F-1:0] c0, input logic [F-1:0] c1,
                       input logic [F-1:0] c2, input logic [F-1:0] c3,
                       input int exp_label, input int exp_conf8, input int exp_conf6);
    set_px(v, h, c0, c1, c2, c3);
    repeat (3) step();
    chk({tag, "_label"},  32'(out_label),  32'(exp_label));
    chk({tag, "_conf8"},  32'(out_conf),   32'(exp_conf8));
    chk({tag, "_label6"}, 32'(out_label6), 32'(exp_label));
    chk({tag, "_conf6"},  32'(out_conf6),  32'(exp_conf6));
    chk({tag, "_vcnt"},   32'(out_vcnt),   32'(v));
    chk({tag, "_hcnt"},   32'(out_hcnt),   32'(h));
  endtask

  // mode 0: every pixel wins on class 2; mode 1: pixel wins on class == hcnt
  task automatic drive_frame(input int mode);
    for (int v = 0; v < 4; v++) begin
      for (int h = 0; h < 4; h++) begin
        if (mode == 0) set_px(v, h, 13'h000, 13'h000, 13'h100, 13'h000);
        else if (h == 0) set_px(v, h, 13'h100, 13'h000, 13'h000, 13'h000);
        else if (h == 1) set_px(v, h, 13'h000, 13'h100, 13'h000, 13'h000);
        else if (h == 2) set_px(v, h, 13'h000, 13'h000, 13'h100, 13'h000);
        else             set_px(v, h, 13'h000, 13'h000, 13'h000, 13'h100);
        step();
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_px(1, 2, 13'h000, 13'h000, 13'h000, 13'h000);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_label", 32'(out_label), 32'd0);
    chk("rst_conf",  32'(out_conf),  32'd0);
    chk("rst_vcnt",  32'(out_vcnt),  32'd0);
    chk("rst_hcnt",  32'(out_hcnt),  32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
`ifdef SEG_HIST_EN
    chk("rst_hist_out",   32'(hist_out),   32'd0);
    chk("rst_hist_valid", 32'(hist_valid), 32'd0);
`endif

    rst_n = 1'b1;
    step();
    chk("valid_edge1", 32'(out_valid), 32'd0);
    step();
    chk("valid_edge2", 32'(out_valid), 32'd0);
    step();
    chk("valid_edge3", 32'(out_valid), 32'd1);

    // datapath vectors
    apply("sat",      1, 2, 13'h100, 13'h180, 13'h1FFF, 13'h080, 1, 255, 63);
    apply("tie_all",  2, 1, 13'h0C0, 13'h0C0, 13'h0C0,  13'h0C0, 0, 192, 48);
    apply("negative", 1, 3, 13'h1F00, 13'h1F00, 13'h1F00, 13'h1F80, 3, 0, 0);
    apply("fe",       3, 1, 13'h0FE, 13'h000, 13'h000, 13'h000, 0, 254, 63);
    apply("half_up",  2, 2, 13'h000, 13'h000, 13'h0FA, 13'h0F9, 2, 250, 63);
    apply("round_dn", 1, 1, 13'h000, 13'h000, 13'h000, 13'h0F9, 3, 249, 62);
    apply("tie_s2",   2, 3, 13'h000, 13'h050, 13'h000, 13'h050, 1, 80, 20);

`ifdef SEG_HIST_EN
    chk("no_pulse_before_frame", 32'(pulse_cnt), 32'd0);

    drive_frame(0);
    set_px(1, 1, 13'h000, 13'h000, 13'h000, 13'h000);
    step();
    step();
    chk("f1_last_vcnt", 32'(out_vcnt), 32'd3);
    chk("f1_last_hcnt", 32'(out_hcnt), 32'd3);
    chk("f1_hv_early",  32'(hist_valid), 32'd0);
    step();
    chk("f1_hv_pulse",  32'(hist_valid), 32'd1);
    chk("f1_hist",      32'(hist_out), 32'(mk_hist(0, 0, 16, 0)));
    step();
    chk("f1_hv_drop",   32'(hist_valid), 32'd0);
    chk("f1_hist_hold", 32'(hist_out), 32'(mk_hist(0, 0, 16, 0)));

    drive_frame(1);
    set_px(1, 1, 13'h000, 13'h000, 13'h000, 13'h000);
    repeat (4) step();
    chk("f2_pulses", 32'(pulse_cnt), 32'd2);
    chk("f2_hist",   32'(hist_out), 32'(mk_hist(4, 4, 4, 4)));
    chk("f2_width",  32'(max_run), 32'd1);
`endif

    // mid-frame reset with pixel (2,1) at the output
    for (int p = 0; p < 10; p++) begin
      set_px(p / 4, p % 4, 13'h000, 13'h000, 13'h100, 13'h000);
      step();
    end
    set_px(2, 2, 13'h000, 13'h000, 13'h100, 13'h000);
    step();
    set_px(2, 3, 13'h000, 13'h000, 13'h100, 13'h000);
    step();
    chk("mid_vcnt",  32'(out_vcnt),  32'd2);
    chk("mid_hcnt",  32'(out_hcnt),  32'd1);
    chk("mid_label", 32'(out_label), 32'd2);
    chk("mid_conf",  32'(out_conf),  32'd255);
    rst_n = 1'b0;
    #1;
    chk("arst_label", 32'(out_label), 32'd0);
    chk("arst_conf",  32'(out_conf),  32'd0);
    chk("arst_vcnt",  32'(out_vcnt),  32'd0);
    chk("arst_hcnt",  32'(out_hcnt),  32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
`ifdef SEG_HIST_EN
    chk("arst_hist_out", 32'(hist_out), 32'd0);
`endif
    step();
    step();
    rst_n = 1'b1;
    set_px(3, 0, 13'h000, 13'h000, 13'h100, 13'h000);
    step();
    chk("rel_valid1", 32'(out_valid), 32'd0);
    set_px(3, 1, 13'h000, 13'h000, 13'h100, 13'h000);
    step();
    chk("rel_valid2", 32'(out_valid), 32'd0);
    set_px(3, 2, 13'h000, 13'h000, 13'h100, 13'h000);
    step();
    chk("rel_valid3", 32'(out_valid), 32'd1);
    set_px(3, 3, 13'h000, 13'h000, 13'h100, 13'h000);
    step();
    set_px(1, 1, 13'h000, 13'h000, 13'h000, 13'h000);
    repeat (4) step();
`ifdef SEG_HIST_EN
    chk("partial_no_pulse", 32'(pulse_cnt), 32'd2);
    chk("partial_hist",     32'(hist_out),  32'd0);

    drive_frame(0);
    set_px(1, 1, 13'h000, 13'h000, 13'h000, 13'h000);
    repeat (4) step();
    chk("f3_pulses", 32'(pulse_cnt), 32'd3);
    chk("f3_hist",   32'(hist_out),  32'(mk_hist(0, 0, 16, 0)));
    chk("f3_width",  32'(max_run),   32'd1);
`endif

    // final report
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
